mouse_cursor: RTL and testbench

Downstream consumer of the PS/2 mouse core's free-running wrap-around counters (x, y, z, buttons). Converts counter changes into signed deltas and accumulates them into a screen-clamped cursor position, a saturating wheel value, and button press/release pulses. Feeds video-overlay and CPU-register logic with a one-cycle update strobe.

---
 rtl/mouse_cursor.sv | 156 +++++++++++++++
 tb/tb_mouse_cursor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mouse_cursor.sv
// Turns free-running PS/2 x/y/z/button counters into a clamped cursor, saturating wheel and button edges.
// Latency: input sampled at edge k shows on outputs after edge k+2 with update; no backpressure.
module mouse_cursor #(
   parameter int c_xy_bits  = 11,
   parameter int c_z_bits   = 11,
   parameter int c_x_res    = 640,
   parameter int c_y_res    = 480,
   parameter int c_y_invert = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [c_xy_bits-1:0] x_in,
   input  logic [c_xy_bits-1:0] y_in,
   input  logic [c_z_bits-1:0]  z_in,
   input  logic [2:0]           btn_in,
   input  logic                 set_pos,
   input  logic [c_xy_bits-1:0] set_x,
   input  logic [c_xy_bits-1:0] set_y,
   output logic [c_xy_bits-1:0] cursor_x,
   output logic [c_xy_bits-1:0] cursor_y,
   output logic [7:0]           wheel,
   output logic [2:0]           btn,
   output logic [2:0]           btn_press,
   output logic [2:0]           btn_release,
   output logic                 update
);
   localparam int SW = c_xy_bits + 2;
   localparam int WS = c_z_bits + 2;
   localparam logic [c_xy_bits-1:0] X_MAX = c_xy_bits'(c_x_res - 1);
   localparam logic [c_xy_bits-1:0] Y_MAX = c_xy_bits'(c_y_res - 1);
   localparam logic [c_xy_bits-1:0] X_MID = c_xy_bits'(c_x_res / 2);
   localparam logic [c_xy_bits-1:0] Y_MID = c_xy_bits'(c_y_res / 2);
   localparam logic signed [SW-1:0] X_MAX_S = SW'(c_x_res - 1);
   localparam logic signed [SW-1:0] Y_MAX_S = SW'(c_y_res - 1);
   localparam logic signed [WS-1:0] W_HI = WS'(127);
   localparam logic signed [WS-1:0] W_LO = WS'(-128);

   logic [c_xy_bits-1:0] x_s0_q, x_s0_d, y_s0_q, y_s0_d;
   logic [c_z_bits-1:0]  z_s0_q, z_s0_d;
   logic [2:0]           btn_s0_q, btn_s0_d;

   logic [c_xy_bits-1:0] x_prev_q, x_prev_d, y_prev_q, y_prev_d;
   logic [c_z_bits-1:0]  z_prev_q, z_prev_d;
   logic [c_xy_bits-1:0] dx_q, dx_d, dy_q, dy_d;
   logic [c_z_bits-1:0]  dz_q, dz_d;
   logic [2:0]           btn_s1_q, btn_s1_d;
   logic                 primed_q, primed_d;

   logic [c_xy_bits-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
   logic [7:0]           wheel_q, wheel_d;
   logic [2:0]           btn_q, btn_d, press_q, press_d, release_q, release_d;
   logic                 update_q, update_d;

   logic signed [SW-1:0] sum_x, sum_y, dy_ext;
   logic signed [WS-1:0] sum_w;

   always_comb begin
      x_s0_d   = x_in;
      y_s0_d   = y_in;
      z_s0_d   = z_in;
      btn_s0_d = btn_in;

      // The first cycle after reset only captures the reference counts, so
      // whatever the counters did before reset never turns into motion.
      primed_d = 1'b1;
      x_prev_d = x_s0_q;
      y_prev_d = y_s0_q;
      z_prev_d = z_s0_q;
      btn_s1_d = btn_s0_q;
      dx_d     = '0;
      dy_d     = '0;
      dz_d     = '0;
      if (primed_q) begin
         dx_d = x_s0_q - x_prev_q;
         dy_d = y_s0_q - y_prev_q;
         dz_d = z_s0_q - z_prev_q;
      end

      dy_ext = $signed({{2{dy_q[c_xy_bits-1]}}, dy_q});
      sum_x  = $signed({2'b00, cur_x_q}) + $signed({{2{dx_q[c_xy_bits-1]}}, dx_q});
      if (c_y_invert != 0) sum_y = $signed({2'b00, cur_y_q}) - dy_ext;
      else                 sum_y = $signed({2'b00, cur_y_q}) + dy_ext;
      sum_w  = $signed({{(WS-8){wheel_q[7]}}, wheel_q}) + $signed({{2{dz_q[c_z_bits-1]}}, dz_q});

      if (sum_x[SW-1])         cur_x_d = '0;
      else if (sum_x > X_MAX_S) cur_x_d = X_MAX;
      else                     cur_x_d = sum_x[c_xy_bits-1:0];

      if (sum_y[SW-1])         cur_y_d = '0;
      else if (sum_y > Y_MAX_S) cur_y_d = Y_MAX;
      else                     cur_y_d = sum_y[c_xy_bits-1:0];

      if (set_pos) begin
         cur_x_d = (set_x > X_MAX) ? X_MAX : set_x;
         cur_y_d = (set_y > Y_MAX) ? Y_MAX : set_y;
      end

      if (sum_w > W_HI)      wheel_d = 8'h7f;
      else if (sum_w < W_LO) wheel_d = 8'h80;
      else                   wheel_d = sum_w[7:0];

      btn_d     = btn_s1_q;
      press_d   = btn_s1_q & ~btn_q;
      release_d = ~btn_s1_q & btn_q;
      update_d  = (cur_x_d != cur_x_q) || (cur_y_d != cur_y_q) ||
                  (wheel_d != wheel_q) || (btn_d != btn_q);
   end

   always_ff @(posedge clk) begin
      x_s0_q   <= x_s0_d;
      y_s0_q   <= y_s0_d;
      z_s0_q   <= z_s0_d;
      btn_s0_q <= btn_s0_d;
      x_prev_q <= x_prev_d;
      y_prev_q <= y_prev_d;
      z_prev_q <= z_prev_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         primed_q  <= 1'b0;
         dx_q      <= '0;
         dy_q      <= '0;
         dz_q      <= '0;
         btn_s1_q  <= '0;
         cur_x_q   <= X_MID;
         cur_y_q   <= Y_MID;
         wheel_q   <= '0;
         btn_q     <= '0;
         press_q   <= '0;
         release_q <= '0;
         update_q  <= 1'b0;
      end else begin
         primed_q  <= primed_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         dz_q      <= dz_d;
         btn_s1_q  <= btn_s1_d;
         cur_x_q   <= cur_x_d;
         cur_y_q   <= cur_y_d;
         wheel_q   <= wheel_d;
         btn_q     <= btn_d;
         press_q   <= press_d;
         release_q <= release_d;
         update_q  <= update_d;
      end
   end

   assign cursor_x    = cur_x_q;
   assign cursor_y    = cur_y_q;
   assign wheel       = wheel_q;
   assign btn         = btn_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign update      = update_q;
endmodule

// File: tb/tb_mouse_cursor.sv
// Bench for mouse_cursor: directed scenarios plus random counter motion against a cycle-level reference model.
module tb_mouse_cursor;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] x_in = '0, y_in = '0, set_x = '0, set_y = '0;
   logic [10:0] z_in = '0;
   logic [2:0]  btn_in = '0;
   logic        set_pos = 1'b0;
   logic [10:0] cursor_x, cursor_y;
   logic [7:0]  wheel;
   logic [2:0]  btn, btn_press, btn_release;
   logic        update;

   mouse_cursor dut (
      .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .z_in(z_in), .btn_in(btn_in),
      .set_pos(set_pos), .set_x(set_x), .set_y(set_y), .cursor_x(cursor_x), .cursor_y(cursor_y),
      .wheel(wheel), .btn(btn), .btn_press(btn_press), .btn_release(btn_release), .update(update)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   // mouse-side counters driven onto the inputs
   int xc = 0, yc = 0, zc = 0;
   logic [2:0] bc = '0;

   // reference model: what the cursor should be, plus the last three samples
   int mx = 320, my = 240, mw = 0;
   logic [2:0] mb = '0, mp = '0, mr = '0;
   logic mu = 1'b0;
   int xh[1:3], yh[1:3], zh[1:3];
   logic [2:0] bh[1:3];
   logic rh[1:3] = '{1'b1, 1'b1, 1'b1};

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int wrap(input int a, input int bits);
      int d;
      d = a & ((1 << bits) - 1);
      if (d >= (1 << (bits - 1))) d -= (1 << bits);
      return d;
   endfunction

   function automatic int clampi(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic step(input logic r, input logic sp, input int sx, input int sy);
      int dx, dy, dz, px, py, pw;
      logic [2:0] nb, pb;
      @(negedge clk);
      reset   = r;
      set_pos = sp;
      set_x   = 11'(sx);
      set_y   = 11'(sy);
      x_in    = 11'(xc);
      y_in    = 11'(yc);
      z_in    = 11'(zc);
      btn_in  = bc;
      @(posedge clk);
      if (r) begin
         mx = 320; my = 240; mw = 0; mb = '0; mp = '0; mr = '0; mu = 1'b0;
      end else begin
         px = mx; py = my; pw = mw; pb = mb;
         // a movement sampled two edges ago counts only if neither later edge was reset/priming
         if (!rh[1] && !rh[2]) begin
            dx = wrap(xh[2] - xh[3], 11);
            dy = wrap(yh[2] - yh[3], 11);
            dz = wrap(zh[2] - zh[3], 11);
         end else begin
            dx = 0; dy = 0; dz = 0;
         end
         if (sp) begin
            mx = (sx > 639) ? 639 : sx;
            my = (sy > 479) ? 479 : sy;
         end else begin
            mx = clampi(mx + dx, 639);
            my = clampi(my - dy, 479);
         end
         mw = mw + dz;
         if (mw > 127) mw = 127;
         if (mw < -128) mw = -128;
         nb = rh[1] ? 3'b000 : bh[2];
         mp = nb & ~pb;
         mr = ~nb & pb;
         mb = nb;
         mu = (mx != px) || (my != py) || (mw != pw) || (mb != pb);
      end
      for (int i = 3; i > 1; i--) begin
         xh[i] = xh[i-1]; yh[i] = yh[i-1]; zh[i] = zh[i-1]; bh[i] = bh[i-1]; rh[i] = rh[i-1];
      end
      xh[1] = xc & 2047; yh[1] = yc & 2047; zh[1] = zc & 2047; bh[1] = bc; rh[1] = r;
      #1;
      check("cursor_x", int'(cursor_x), mx);
      check("cursor_y", int'(cursor_y), my);
      check("wheel", int'($signed(wheel)), mw);
      check("btn", int'(btn), int'(mb));
      check("btn_press", int'(btn_press), int'(mp));
      check("btn_release", int'(btn_release), int'(mr));
      check("update", int'(update), int'(mu));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0);
   endtask

   initial begin
      // counters parked far from centre: no jump after priming
      xc = 1000; yc = 500; zc = 0; bc = '0;
      do_reset(3);
      check("reset_cx", int'(cursor_x), 320);
      check("reset_update", int'(update), 0);
      idle(8);
      check("prime_cx", int'(cursor_x), 320);
      check("prime_cy", int'(cursor_y), 240);

      // wrap 2047 -> 0 -> 1 counts as two +1 steps
      xc = 2047;
      do_reset(2);
      idle(4);
      xc = 0;  idle(4);
      xc = 1;  idle(4);
      check("wrap_cx", int'(cursor_x), 322);

      // large negative step clamps at the left edge, further motion absorbed
      xc = (xc - 400) & 2047; idle(4);
      check("clamp_lo_cx", int'(cursor_x), 0);
      xc = (xc - 10) & 2047;  idle(4);
      check("clamp_hold_cx", int'(cursor_x), 0);

      // +y moves up; wheel saturates both ways
      yc = (yc + 5) & 2047;   idle(4);
      check("invert_cy", int'(cursor_y), 235);
      zc = (zc + 200) & 2047; idle(4);
      check("wheel_hi", int'($signed(wheel)), 127);
      zc = (zc - 150) & 2047; idle(2);
      zc = (zc - 150) & 2047; idle(4);
      check("wheel_lo", int'($signed(wheel)), -128);

      // button press/release sequence
      bc = 3'b001; idle(3);
      bc = 3'b011; idle(3);
      bc = 3'b000; idle(3);

      // set_pos wins over a same-edge movement
      xc = (xc + 3) & 2047;
      idle(2);
      step(1'b0, 1'b1, 700, 10);
      idle(3);
      check("setpos_cx", int'(cursor_x), 639);
      check("setpos_cy", int'(cursor_y), 10);

      // reset in the middle of motion
      for (int i = 0; i < 4; i++) begin
         xc = (xc + 37) & 2047; yc = (yc + 11) & 2047; idle(1);
      end
      xc = (xc + 50) & 2047; step(1'b1, 1'b0, 0, 0);
      xc = (xc + 50) & 2047; step(1'b1, 1'b0, 0, 0);
      idle(6);
      check("midreset_cx", int'(cursor_x), 320);
      check("midreset_cy", int'(cursor_y), 240);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         int sel;
         logic r, sp;
         sel = $urandom_range(0, 9);
         if (sel < 6) begin
            xc = (xc + $urandom_range(0, 16) - 8) & 2047;
            yc = (yc + $urandom_range(0, 16) - 8) & 2047;
            zc = (zc + $urandom_range(0, 6) - 3) & 2047;
         end else if (sel < 8) begin
            xc = (xc + $urandom_range(0, 1400) - 700) & 2047;
            yc = (yc + $urandom_range(0, 1400) - 700) & 2047;
            zc = (zc + $urandom_range(0, 400) - 200) & 2047;
         end
         if ($urandom_range(0, 5) == 0) bc = 3'($urandom_range(0, 7));
         r  = ($urandom_range(0, 99) == 0);
         sp = ($urandom_range(0, 39) == 0);
         step(r, sp, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
